// File: rtl/psum_accum_ctrl_pkg.sv
// Shared types and default sizing for the partial-sum accumulation controller.
package psum_ctrl_pkg;

  // Controller sequence: wait, read a row, accumulate, write back, end of pass.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    ACC,
    WR,
    DONE
  } state_t;

  localparam int col_def     = 8;
  localparam int psum_bw_def = 16;
  localparam int npix_def    = 16;
  localparam int nkij_def    = 9;
  localparam int addr_w_def  = 9;

endpackage

// File: rtl/psum_accum_ctrl_lane_adder.sv
// psum_lane_adder: combinational col-lane adder. Each lane wraps modulo
// 2^psum_bw with no carry into its neighbour. zero_acc drops the PMEM operand
// (first kernel position); relu_en clamps negative lane sums to zero.
module psum_lane_adder
  import psum_ctrl_pkg::*;
#(
  parameter int col     = col_def,
  parameter int psum_bw = psum_bw_def
) (
  input  logic [col*psum_bw-1:0] op,
  input  logic [col*psum_bw-1:0] acc,
  input  logic                   zero_acc,
  input  logic                   relu_en,
  output logic [col*psum_bw-1:0] sum
);

  logic [psum_bw-1:0] lane;

  // Per-lane add with optional PMEM operand and optional negative clamp.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sum  = '0;
    lane = '0;
    for (int i = 0; i < col; i++) begin
      lane = op[i*psum_bw +: psum_bw] + (zero_acc ? '0 : acc[i*psum_bw +: psum_bw]);
      if (relu_en && lane[psum_bw-1]) begin
        lane = '0;
      end
      sum[i*psum_bw +: psum_bw] = lane;
    end
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: drains the output FIFO one pixel row at a time and does a
// read-modify-write into PMEM, accumulating across the nkij kernel positions
// of one convolution. One start pulse runs one pass of npix rows.
// Optional macro PSUM_RELU_EN: clamp negative lanes to zero on the last pass.
module psum_accum_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int col     = col_def,
  parameter int psum_bw = psum_bw_def,
  parameter int npix    = npix_def,
  parameter int nkij    = nkij_def,
  parameter int addr_w  = addr_w_def
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  output logic                   busy,
  output logic                   pass_done,
  output logic                   all_done,
  output logic [3:0]             kij_idx,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  input  logic [col*psum_bw-1:0] pmem_q,
  output logic [col*psum_bw-1:0] pmem_d,
  output logic [addr_w-1:0]      pmem_addr,
  output logic                   pmem_cen,
  output logic                   pmem_wen
);

  localparam int nij_w = (npix > 1) ? $clog2(npix) : 1;
  localparam int row_w = col * psum_bw;

  state_t             state;
  state_t             state_next;
  logic [nij_w-1:0]   nij;
  logic [row_w-1:0]   op_reg;
  logic [row_w-1:0]   sum_reg;
  logic [row_w-1:0]   sum_next;
  logic [addr_w-1:0]  row_addr;
  logic               first_pass;
  logic               last_pass;
  logic               last_row;
  logic               relu_en;

  assign first_pass = (kij_idx == 4'd0);
  assign last_pass  = (kij_idx == 4'(nkij - 1));
  assign last_row   = (nij == nij_w'(npix - 1));
  // Wraps modulo 2^addr_w when the tile runs past the top of PMEM.
  assign row_addr   = base_addr + addr_w'(nij);

`ifdef PSUM_RELU_EN
  assign relu_en = last_pass;
`else
  assign relu_en = 1'b0;
`endif

  psum_lane_adder #(
    .col     (col),
    .psum_bw (psum_bw)
  ) u_lane_adder (
    .op       (op_reg),
    .acc      (pmem_q),
    .zero_acc (first_pass),
    .relu_en  (relu_en),
    .sum      (sum_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RD;
      RD:      if (ofifo_valid) state_next = ACC;
      ACC:     state_next = WR;
      WR:      state_next = last_row ? DONE : RD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row counter, pass counter and the operand/sum pipeline registers.
  always_ff @(posedge clk) begin
    // NOTE: sum_reg drives pmem_d directly, so the data registers are reset to give pmem_d = 0 out of reset.
    if (reset) begin
      nij     <= '0;
      kij_idx <= 4'd0;
      op_reg  <= '0;
      sum_reg <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) nij <= '0;
        RD:   if (ofifo_valid) op_reg <= ofifo_out;
        ACC:  sum_reg <= sum_next;
        WR:   if (!last_row) nij <= nij + nij_w'(1);
        DONE: kij_idx <= last_pass ? 4'd0 : kij_idx + 4'd1;
        default: ;
      endcase
    end
  end

  // pmem_d follows sum_reg, which only changes in ACC, so it holds the
  // last written row everywhere outside WR.
  assign pmem_d = sum_reg;

  // Moore decode of FIFO/PMEM strobes and status pulses.
  always_comb begin
    busy      = (state != IDLE);
    pass_done = 1'b0;
    all_done  = 1'b0;
    ofifo_rd  = 1'b0;
    pmem_cen  = 1'b1;
    pmem_wen  = 1'b1;
    pmem_addr = '0;
    unique case (state)
      RD: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          if (!first_pass) begin
            pmem_cen  = 1'b0;
            pmem_addr = row_addr;
          end
        end
      end
      WR: begin
        pmem_cen  = 1'b0;
        pmem_wen  = 1'b0;
        pmem_addr = row_addr;
      end
      DONE: begin
        pass_done = 1'b1;
        all_done  = last_pass;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench for psum_accum_ctrl: stimulus pushes expected PMEM writes,
// reads and pass_done events; a negedge monitor pops and compares them.
module tb_psum_accum_ctrl;
  import psum_ctrl_pkg::*;

  localparam int col  = 8;
  localparam int bw   = 16;
  localparam int npix = 16;
  localparam int nkij = 9;
  localparam int aw   = 9;
  localparam int rw   = col * bw;

`ifdef PSUM_RELU_EN
  localparam bit relu_on = 1'b1;
`else
  localparam bit relu_on = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [aw-1:0] base_addr;
  logic          busy, pass_done, all_done, ofifo_rd, pmem_cen, pmem_wen;
  logic [3:0]    kij_idx;
  logic          ofifo_valid;
  logic [rw-1:0] ofifo_out, pmem_q, pmem_d;
  logic [aw-1:0] pmem_addr;

  psum_accum_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .busy        (busy),
    .pass_done   (pass_done),
    .all_done    (all_done),
    .kij_idx     (kij_idx),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .pmem_q      (pmem_q),
    .pmem_d      (pmem_d),
    .pmem_addr   (pmem_addr),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [rw-1:0] act, input logic [rw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- PMEM: synchronous single-port memory ----------------
  logic [rw-1:0] pmem [0:511];
  always @(posedge clk) begin
    if (!pmem_cen) begin
      if (pmem_wen) pmem_q <= pmem[pmem_addr];
      else          pmem[pmem_addr] <= pmem_d;
    end
  end

  // ---------------- Reference model ----------------
  logic [rw-1:0] ref_mem [0:511];
  int            ref_kij = 0;

  // Lanewise two's-complement add with wrap, optional clamp of negatives.
  function automatic logic [rw-1:0] add_rows(input logic [rw-1:0] a, input logic [rw-1:0] b,
                                             input bit clamp);
    logic [rw-1:0] r;
    logic [bw-1:0] la, lb;
    int            v;
    r = '0;
    for (int i = 0; i < col; i++) begin
      la = a[i*bw +: bw];
      lb = b[i*bw +: bw];
      v  = int'($signed(la)) + int'($signed(lb));
      if (v > 32767)  v -= 65536;
      if (v < -32768) v += 65536;
      if (clamp && v < 0) v = 0;
      r[i*bw +: bw] = v[bw-1:0];
    end
    return r;
  endfunction

  typedef struct { logic [aw-1:0] addr; logic [rw-1:0] data; } wr_t;
  typedef struct { int kij; bit all; int lat; int start_cyc; } pd_t;
  typedef struct { logic [rw-1:0] data; int gap; } row_t;

  wr_t           wr_q[$];
  pd_t           pd_q[$];
  logic [aw-1:0] rd_q[$];
  row_t          fifo_q[$];
  bit            ignore_mem = 1'b0;

  // ---------------- ofifo driver ----------------
  // A row's gap counts cycles it sits at the head withheld; the first two
  // overlap ACC/WR of the previous row, so a stall in RD is gap-2 cycles.
  logic rd_seen;
  initial begin
    ofifo_valid = 1'b0;
    ofifo_out   = '0;
    forever begin
      @(negedge clk);
      rd_seen = ofifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (fifo_q.size() > 0) begin
        if (fifo_q[0].gap > 0) begin
          ofifo_valid = 1'b0;
          fifo_q[0].gap--;
        end else begin
          ofifo_valid = 1'b1;
          ofifo_out   = fifo_q[0].data;
        end
      end else begin
        ofifo_valid = 1'b0;
      end
    end
  end

  // ---------------- Monitor ----------------
  initial begin
    wr_t e;
    pd_t p;
    logic [aw-1:0] ra;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!ofifo_valid) check("no_pop_or_read_when_empty", rw'({ofifo_rd, !pmem_cen && pmem_wen}), '0);
        if (!pmem_cen && !pmem_wen && !ignore_mem) begin
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL write_unexpected: write at addr %h data %h, none expected", pmem_addr, pmem_d);
          end else begin
            e = wr_q.pop_front();
            check("write_addr", rw'(pmem_addr), rw'(e.addr));
            check("write_data", pmem_d, e.data);
          end
        end
        if (!pmem_cen && pmem_wen && !ignore_mem) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL read_unexpected: read at addr %h, none expected", pmem_addr);
          end else begin
            ra = rd_q.pop_front();
            check("read_addr", rw'(pmem_addr), rw'(ra));
          end
        end
        if (pass_done) begin
          if (pd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pass_done_unexpected: pass_done=1 expected 0");
          end else begin
            p = pd_q.pop_front();
            check("pass_kij", rw'(kij_idx), rw'(p.kij));
            check("all_done", rw'(all_done), rw'(p.all));
            check("pass_latency", rw'(cyc - p.start_cyc + 1), rw'(p.lat));
          end
        end else if (all_done) begin
          checks++; errors++;
          $display("FAIL all_done_alone: all_done=1 without pass_done");
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic run_pass(input logic [aw-1:0] base, input logic [rw-1:0] rows [npix],
                          input int gap_row, input int gap, input bit poke_start);
    logic [aw-1:0] a;
    logic [rw-1:0] prev, s;
    int            n;
    @(negedge clk);
    for (int r = 0; r < npix; r++) begin
      a    = base + aw'(r);
      prev = (ref_kij == 0) ? '0 : ref_mem[a];
      if (ref_kij != 0) rd_q.push_back(a);
      s = add_rows(rows[r], prev, relu_on && (ref_kij == nkij - 1));
      ref_mem[a] = s;
      wr_q.push_back('{a, s});
      fifo_q.push_back('{rows[r], (r == gap_row) ? gap : 0});
    end
    pd_q.push_back('{ref_kij, ref_kij == nkij - 1,
                     3 * npix + 2 + ((gap > 2) ? gap - 2 : 0), cyc});
    ref_kij   = (ref_kij + 1) % nkij;
    base_addr = base;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("pass_ends_idle", rw'(busy), '0);
    repeat (3) @(negedge clk);
    check("idle_after_pass", rw'(busy), '0);
    check("kij_after_pass", rw'(kij_idx), rw'(ref_kij));
  endtask

  function automatic logic [rw-1:0] splat(input logic [bw-1:0] v);
    return {col{v}};
  endfunction

  logic [rw-1:0] rows [npix];
  logic [aw-1:0] rbase;

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    base_addr = '0;
    for (int i = 0; i < 512; i++) begin
      pmem[i]    = '0;
      ref_mem[i] = '0;
    end

    // Reset held 3 cycles with start high.
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", rw'(busy), '0);
      check("rst_pulses", rw'({pass_done, all_done, ofifo_rd}), '0);
      check("rst_cen_wen", rw'({pmem_cen, pmem_wen}), rw'(2'b11));
      check("rst_addr", rw'(pmem_addr), '0);
      check("rst_d", pmem_d, '0);
      check("rst_kij", rw'(kij_idx), '0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_in_reset_ignored", rw'(busy), '0);

    // Conv A at 0x040: pass 0 lanes = nij+1, then lanes = 3, one stalled pass.
    for (int r = 0; r < npix; r++) rows[r] = splat(bw'(r + 1));
    run_pass(9'h040, rows, -1, 0, 1'b0);
    for (int r = 0; r < npix; r++) rows[r] = splat(16'h0003);
    for (int k = 1; k < nkij; k++) run_pass(9'h040, rows, (k == 3) ? 7 : -1, (k == 3) ? 7 : 0, 1'b0);

    // Conv B at 0x100: nine passes of 3 -> 0x001B per lane.
    for (int k = 0; k < nkij; k++) run_pass(9'h100, rows, -1, 0, 1'b0);
    check("convB_final", ref_mem[9'h105], splat(16'h001B));

    // Two random passes, then reset in the middle of the third.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < npix; r++) for (int l = 0; l < col; l++) rows[r][l*bw +: bw] = bw'($urandom);
      run_pass(9'h0C0, rows, -1, 0, 1'b0);
    end
    @(negedge clk);
    ignore_mem = 1'b1;
    for (int r = 0; r < npix; r++) fifo_q.push_back('{rows[r], 0});
    base_addr = 9'h0C0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("midpass_busy", rw'(busy), rw'(1'b1));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_busy", rw'(busy), '0);
    check("midrst_kij", rw'(kij_idx), '0);
    reset = 1'b0;
    fifo_q.delete();
    ref_kij = 0;
    repeat (8) begin
      @(negedge clk);
      check("no_write_after_reset", rw'({busy, pmem_cen}), rw'(2'b01));
    end
    ignore_mem = 1'b0;

    // Conv C at 0x1F8 (address wrap): lane0 0x7FFF + 0x0001 -> 0x8000,
    // start pulsed while busy in pass 1.
    for (int k = 0; k < nkij; k++) begin
      for (int r = 0; r < npix; r++) begin
        for (int l = 0; l < col; l++) rows[r][l*bw +: bw] = bw'($urandom);
        if (k == 0) rows[r][bw-1:0] = 16'h7FFF;
        if (k == 1) rows[r][bw-1:0] = 16'h0001;
      end
      run_pass(9'h1F8, rows, -1, 0, k == 1);
      if (k == 1) check("overflow_lane0", rw'(ref_mem[9'h003][bw-1:0]), rw'(16'h8000));
    end

    // Conv D at 0x080: only the final pass contributes -10 / +5.
    for (int k = 0; k < nkij; k++) begin
      for (int r = 0; r < npix; r++) begin
        rows[r] = '0;
        if (k == nkij - 1) begin
          rows[r][bw-1:0]    = 16'hFFF6;
          rows[r][2*bw-1:bw] = 16'h0005;
        end
      end
      run_pass(9'h080, rows, -1, 0, 1'b0);
    end
    check("relu_lane0", rw'(ref_mem[9'h080][bw-1:0]), relu_on ? '0 : rw'(16'hFFF6));
    check("relu_lane1", rw'(ref_mem[9'h080][2*bw-1:bw]), rw'(16'h0005));

    // Conv E: random data, random base, random stall per pass.
    rbase = aw'($urandom);
    for (int k = 0; k < nkij; k++) begin
      for (int r = 0; r < npix; r++) for (int l = 0; l < col; l++) rows[r][l*bw +: bw] = bw'($urandom);
      run_pass(rbase, rows, $urandom_range(1, npix - 1), $urandom_range(0, 8), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("wr_queue_empty", rw'(wr_q.size()), '0);
    check("rd_queue_empty", rw'(rd_q.size()), '0);
    check("pd_queue_empty", rw'(pd_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
